sad_feeder: RTL



---
 rtl/sad_feeder.sv | 115 +++++++++++
 1 files changed

// File: rtl/sad_feeder.sv
// Sequencer for one SAD search: clears the 3x3 array, streams the search window and
// the template block from synchronous-read memories, waits for the result, then offers it.
module sad_feeder #(
  parameter int BLK   = 16,
  parameter int PRE   = 34,
  parameter int DRAIN = 5,
  parameter int SWAW  = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            tb_rd,
  output logic [7:0]      tb_addr,
  input  logic [7:0]      tb_data,
  output logic            sw_rd,
  output logic [SWAW-1:0] sw_addr,
  input  logic [7:0]      sw_data,
  output logic            clr,
  output logic            en_sw,
  output logic            en_tb,
  output logic [7:0]      pel_sw,
  output logic [7:0]      pel_tb,
  input  logic [15:0]     sad_in,
  input  logic [3:0]      vec_diff_in,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [15:0]     res_sad,
  output logic [3:0]      res_vec
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

  localparam int TBN = BLK * BLK;
  localparam int DW  = $clog2(DRAIN + 2);

  logic [2:0]    state;
  logic [DW-1:0] drain_cnt;
  logic          sw_d1;
  logic          tb_d1;

  assign busy      = (state != S_IDLE);
  assign clr       = (state == S_CLEAR);
  assign sw_rd     = (state == S_LOAD) || (state == S_RUN);
  assign tb_rd     = (state == S_RUN);
  assign res_valid = (state == S_OUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
      sw_addr   <= '0;
      tb_addr   <= '0;
      sw_d1     <= 1'b0;
      tb_d1     <= 1'b0;
      en_sw     <= 1'b0;
      en_tb     <= 1'b0;
      pel_sw    <= '0;
      pel_tb    <= '0;
      res_sad   <= '0;
      res_vec   <= '0;
    end else begin
      // Stage 1 tracks the memory read latency; stage 2 presents the pixel with its enable.
      sw_d1  <= sw_rd;
      tb_d1  <= tb_rd;
      en_sw  <= sw_d1;
      en_tb  <= tb_d1;
      pel_sw <= sw_d1 ? sw_data : '0;
      pel_tb <= tb_d1 ? tb_data : '0;

      case (state)
        S_IDLE: begin
          if (start) begin
            sw_addr <= '0;
            tb_addr <= '0;
            state   <= S_CLEAR;
          end
        end
        S_CLEAR: state <= S_LOAD;
        S_LOAD: begin
          sw_addr <= sw_addr + 1'b1;
          if (sw_addr == SWAW'(PRE - 1)) state <= S_RUN;
        end
        S_RUN: begin
          sw_addr <= sw_addr + 1'b1;
          tb_addr <= tb_addr + 1'b1;
          if (tb_addr == 8'(TBN - 1)) begin
            // Two extra counts cover the strobe pipeline still emptying.
            drain_cnt <= DW'(DRAIN + 1);
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            res_sad <= sad_in;
            res_vec <= vec_diff_in;
            state   <= S_OUT;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        S_OUT: begin
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
